// File: rtl/block_serial_subtractor_32bit_if.sv
// Operand/result handshake bundle for the block-serial 32-bit subtractor.
// The slave modport is the subtractor's view; master is the producer/consumer side.
interface block_serial_subtractor_32bit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        zero;
  logic        ovf;

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/block_serial_subtractor_32bit.sv
// Block-serial 32-bit subtractor: a - b - bin computed BLOCK_W bits per cycle,
// LSB block first, with a registered borrow chained between blocks.
module block_serial_subtractor_32bit #(
  parameter int BLOCK_W = 8
) (
  input logic                          clk,
  input logic                          rst,
  block_serial_subtractor_32bit_if.slave io
);

  localparam int NBLK   = 32 / BLOCK_W;
  localparam int IDX_W  = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int BLK_SH = $clog2(BLOCK_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One block of a + ~b + ~borrow_in; returns {borrow_out, diff_bits}.
  // When every bit pair matches, the ripple borrow-out always equals the
  // borrow-in, so the skip path forwards it directly.
  function automatic logic [BLOCK_W:0] blk_sub(
    input logic [BLOCK_W-1:0] xa,
    input logic [BLOCK_W-1:0] xb,
    input logic               borrow_in
  );
    logic [BLOCK_W:0] sum;
    logic             skip;
    logic             rip_borrow;
    sum        = {1'b0, xa} + {1'b0, ~xb} + {{BLOCK_W{1'b0}}, ~borrow_in};
    rip_borrow = ~sum[BLOCK_W];
    skip       = &(xa ~^ xb);
    return {(skip ? borrow_in : rip_borrow), sum[BLOCK_W-1:0]};
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [31:0]      diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [4:0]         blk_lsb;
  logic [BLOCK_W-1:0] blk_a;
  logic [BLOCK_W-1:0] blk_b;
  logic [BLOCK_W:0]   blk_res;

  assign blk_lsb = 5'(idx_q) << BLK_SH;
  assign blk_a   = a_q[blk_lsb +: BLOCK_W];
  assign blk_b   = b_q[blk_lsb +: BLOCK_W];
  assign blk_res = blk_sub(blk_a, blk_b, borrow_q);

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    borrow_d    = borrow_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d      = io.a;
          b_d      = io.b;
          borrow_d = io.bin;
          idx_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        diff_d[blk_lsb +: BLOCK_W] = blk_res[BLOCK_W-1:0];
        borrow_d                   = blk_res[BLOCK_W];
        if (idx_q == LAST_IDX) begin
          // Flags use the fully assembled result including this last block.
          state_d = DONE;
          bout_d  = blk_res[BLOCK_W];
          zero_d  = (diff_d == 32'd0);
          ovf_d   = (a_q[31] != b_q[31]) & (diff_d[31] != a_q[31]);
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset wins over any handshake in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      borrow_q    <= 1'b0;
      diff_q      <= 32'd0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      borrow_q    <= borrow_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.diff      = diff_q;
  assign io.bout      = bout_q;
  assign io.zero      = zero_q;
  assign io.ovf       = ovf_q;

endmodule
